// File: rtl/boolean_pkg.sv
// Shared definitions for the boolean gate library and its response checker:
// the checker FSM state type and the canonical 2-input truth tables.
package boolean_pkg;

  // Checker sweep states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_e;

  // Truth tables for 2-input gates, bit v is the expected y for inputs {a,b}==v
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage : boolean_pkg

// File: rtl/gate_response_checker_sat_counter.sv
// Saturating up-counter: clears on clr, increments on inc, sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  // Count register: clear has priority over increment; saturate instead of wrapping
  always_ff @(posedge clk) begin
    // NOTE: sequential state is always assigned with <= so every register
    // samples the pre-edge values of its neighbours, independent of block order.
    if (!reset || clr) begin
      r_q <= '0;
    end else if (inc && (r_q != '1)) begin
      r_q <= r_q + 1'b1;
    end
  end

  assign q = r_q;

endmodule : sat_counter

// File: rtl/gate_response_checker.sv
// Self-checking exerciser for a combinational gate under test (GUT).
// Sweeps every input vector, lets each settle, samples y, compares against
// TRUTH and reports a saturating mismatch count, pass flag and first failure.
module gate_response_checker
  import boolean_pkg::*;
#(
  parameter int                   N_IN   = 2,
  parameter logic [2**N_IN-1:0]   TRUTH  = TT_AND,
  parameter int                   SETTLE = 2,
  parameter int                   ERR_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [N_IN-1:0]  dut_in,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic             first_fail_vld
);

  // Settle counter must hold SETTLE; keep at least one bit when SETTLE is 0
  localparam int SW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [SW-1:0]   SETTLE_LD = SW'(SETTLE);
  localparam logic [N_IN-1:0] LAST_VEC  = '1;

  state_e           r_state;
  state_e           w_next;
  logic [N_IN-1:0]  r_vec;
  logic [SW-1:0]    r_settle;
  logic             r_pass;
  logic [N_IN-1:0]  r_ff_vec;
  logic             r_ff_vld;

  logic             w_accept;
  logic             w_mismatch;
  logic             w_busy;
  logic [ERR_W-1:0] w_err;

  assign w_accept   = (r_state == ST_IDLE) && start;
  assign w_mismatch = (r_state == ST_SAMPLE) && (dut_y != TRUTH[r_vec]);
  assign w_busy     = (r_state == ST_DRIVE) || (r_state == ST_SETTLE) ||
                      (r_state == ST_SAMPLE);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic for the sweep
  always_comb begin
    // NOTE: w_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_DRIVE;
      end
      ST_DRIVE: begin
        if (SETTLE == 0) w_next = ST_SAMPLE;
        else             w_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (r_settle == SW'(1)) w_next = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (r_vec == LAST_VEC) w_next = ST_DONE;
        else                   w_next = ST_DRIVE;
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Sweep datapath: vector, settle timer, first-failure capture, held pass flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_vec    <= '0;
      r_settle <= '0;
      r_pass   <= 1'b0;
      r_ff_vec <= '0;
      r_ff_vld <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Results persist in IDLE and are cleared only when a sweep starts
          if (start) begin
            r_vec    <= '0;
            r_pass   <= 1'b0;
            r_ff_vec <= '0;
            r_ff_vld <= 1'b0;
          end
        end
        ST_DRIVE: begin
          r_settle <= SETTLE_LD;
        end
        ST_SETTLE: begin
          r_settle <= r_settle - 1'b1;
        end
        ST_SAMPLE: begin
          if (w_mismatch && !r_ff_vld) begin
            r_ff_vec <= r_vec;
            r_ff_vld <= 1'b1;
          end
          // Last vector is found by compare, so vec never wraps back to 0 here
          if (r_vec != LAST_VEC) begin
            r_vec <= r_vec + 1'b1;
          end
        end
        ST_DONE: begin
          r_pass <= (w_err == '0);
        end
        default: begin
          r_vec <= r_vec;
        end
      endcase
    end
  end

  // Mismatch counter, cleared when a sweep is accepted
  sat_counter #(
    .WIDTH (ERR_W)
  ) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_accept),
    .inc   (w_mismatch),
    .q     (w_err)
  );

  // In DONE the pass flag is taken live from the counter, so a mismatch in the
  // final SAMPLE is already reflected; afterwards the registered copy holds it.
  assign pass           = (r_state == ST_DONE) ? (w_err == '0) : r_pass;
  assign busy           = w_busy;
  assign done           = (r_state == ST_DONE);
  assign dut_in         = w_busy ? r_vec : '0;
  assign err_count      = w_err;
  assign first_fail_vec = r_ff_vec;
  assign first_fail_vld = r_ff_vld;

endmodule : gate_response_checker

// File: tb/tb_gate_response_checker.sv
// Directed bench for gate_response_checker. Several checker instances share
// clock, reset and start, each paired with a different gate under test.
module tb_gate_response_checker;
  import boolean_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic start;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // AND gate checked against TT_AND, default settle
  logic [1:0] a_in;  logic a_y, a_busy, a_done, a_pass, a_vld;
  logic [7:0] a_err; logic [1:0] a_ffv;
  assign a_y = a_in[1] & a_in[0];
  gate_response_checker #(.N_IN(2), .TRUTH(TT_AND), .SETTLE(2), .ERR_W(8)) u_and (
    .clk(clk), .reset(reset), .start(start), .dut_in(a_in), .dut_y(a_y),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
    .first_fail_vec(a_ffv), .first_fail_vld(a_vld));

  // OR gate checked against TT_AND
  logic [1:0] o_in;  logic o_y, o_busy, o_done, o_pass, o_vld;
  logic [7:0] o_err; logic [1:0] o_ffv;
  assign o_y = o_in[1] | o_in[0];
  gate_response_checker #(.N_IN(2), .TRUTH(TT_AND), .SETTLE(2), .ERR_W(8)) u_ovr (
    .clk(clk), .reset(reset), .start(start), .dut_in(o_in), .dut_y(o_y),
    .busy(o_busy), .done(o_done), .pass(o_pass), .err_count(o_err),
    .first_fail_vec(o_ffv), .first_fail_vld(o_vld));

  // y tied low checked against TT_OR
  logic [1:0] z_in;  logic z_busy, z_done, z_pass, z_vld;
  logic [7:0] z_err; logic [1:0] z_ffv;
  gate_response_checker #(.N_IN(2), .TRUTH(TT_OR), .SETTLE(2), .ERR_W(8)) u_zero (
    .clk(clk), .reset(reset), .start(start), .dut_in(z_in), .dut_y(1'b0),
    .busy(z_busy), .done(z_done), .pass(z_pass), .err_count(z_err),
    .first_fail_vec(z_ffv), .first_fail_vld(z_vld));

  // Same as above with a 1-bit error counter
  logic [1:0] w_in;  logic w_busy, w_done, w_pass, w_vld;
  logic [0:0] w_err; logic [1:0] w_ffv;
  gate_response_checker #(.N_IN(2), .TRUTH(TT_OR), .SETTLE(2), .ERR_W(1)) u_zero_w1 (
    .clk(clk), .reset(reset), .start(start), .dut_in(w_in), .dut_y(1'b0),
    .busy(w_busy), .done(w_done), .pass(w_pass), .err_count(w_err),
    .first_fail_vec(w_ffv), .first_fail_vld(w_vld));

  // AND gate with no settle cycles
  logic [1:0] s_in;  logic s_y, s_busy, s_done, s_pass, s_vld;
  logic [7:0] s_err; logic [1:0] s_ffv;
  assign s_y = s_in[1] & s_in[0];
  gate_response_checker #(.N_IN(2), .TRUTH(TT_AND), .SETTLE(0), .ERR_W(8)) u_s0 (
    .clk(clk), .reset(reset), .start(start), .dut_in(s_in), .dut_y(s_y),
    .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
    .first_fail_vec(s_ffv), .first_fail_vld(s_vld));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int m;
    int dc;

    reset = 1'b0;
    start = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_busy",   32'(a_busy), 0);
    check("rst_done",   32'(a_done), 0);
    check("rst_pass",   32'(a_pass), 0);
    check("rst_err",    32'(a_err),  0);
    check("rst_vld",    32'(a_vld),  0);
    check("rst_dut_in", 32'(a_in),   0);
    reset = 1'b1;
    tick();
    check("idle_busy",  32'(a_busy), 0);

    // Full sweep on all instances; start accepted at edge 0, now at cycle 1
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      check("and_dut_in", 32'(a_in),   (c < 17) ? 32'((c - 1) / 4) : 0);
      check("and_done",   32'(a_done), 32'(c == 17));
      check("and_busy",   32'(a_busy), 32'(c < 17));
      check("s0_dut_in",  32'(s_in),   (c < 9) ? 32'((c - 1) / 2) : 0);
      check("s0_done",    32'(s_done), 32'(c == 9));
      if (c < 17) tick();
    end
    // Cycle 17: DONE for the SETTLE=2 instances
    check("and_pass",  32'(a_pass), 1);
    check("and_err",   32'(a_err),  0);
    check("and_vld",   32'(a_vld),  0);
    check("ovr_pass",  32'(o_pass), 0);
    check("ovr_err",   32'(o_err),  2);
    check("ovr_ffv",   32'(o_ffv),  1);
    check("ovr_vld",   32'(o_vld),  1);
    check("zero_err",  32'(z_err),  3);
    check("zero_ffv",  32'(z_ffv),  1);
    check("zero_pass", 32'(z_pass), 0);
    check("w1_err",    32'(w_err),  1);
    check("w1_pass",   32'(w_pass), 0);
    check("w1_done",   32'(w_done), 1);
    tick();
    // Cycle 18: IDLE, results held
    check("hold_and_done", 32'(a_done), 0);
    check("hold_and_pass", 32'(a_pass), 1);
    check("hold_ovr_err",  32'(o_err),  2);
    check("hold_ovr_ffv",  32'(o_ffv),  1);
    check("hold_ovr_pass", 32'(o_pass), 0);
    check("hold_s0_pass",  32'(s_pass), 1);
    check("hold_s0_err",   32'(s_err),  0);

    // Reset in the middle of a sweep
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();            // cycle 8: u_ovr samples vector 1 (a mismatch)
    check("mid_busy", 32'(o_busy), 1);
    reset = 1'b0;
    tick();
    check("abort_busy",   32'(o_busy), 0);
    check("abort_dut_in", 32'(o_in),   0);
    check("abort_err",    32'(o_err),  0);
    check("abort_vld",    32'(o_vld),  0);
    check("abort_pass",   32'(a_pass), 0);
    reset = 1'b1;
    dc = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (a_done) dc++;
    end
    check("abort_no_done", 32'(dc), 0);

    // Fresh sweep after the abort
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!a_done && n < 60) begin
      tick();
      n++;
    end
    check("restart_latency", 32'(n), 17);
    check("restart_ovr_err", 32'(o_err), 2);
    tick();

    // Second start pulse during busy is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    dc = 0;
    for (int i = 0; i < 30; i++) begin
      if (a_done) dc++;
      tick();
    end
    check("ignored_start_dones", 32'(dc), 1);
    check("ignored_start_idle",  32'(a_busy), 0);

    // start held high: back-to-back sweeps
    start = 1'b1;
    tick();
    n = 1;
    while (!a_done && n < 60) begin
      tick();
      n++;
    end
    check("held_first_done", 32'(n), 17);
    m = 0;
    do begin
      tick();
      m++;
    end while (!a_done && m < 60);
    check("held_period", 32'(m), 18);
    start = 1'b0;
    repeat (40) tick();
    check("held_end_busy", 32'(a_busy), 0);
    check("held_end_pass", 32'(a_pass), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_gate_response_checker
